// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - control/status bundle between mc_controller and the MIPS datapath
interface mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             Mem_Ready;
    logic             PCWr;
    logic             nPC_sel;
    logic             Jump;
    logic             IRWr;
    logic             InstRd;
    logic             MemRd;
    logic             MemWr;
    logic             RegWr;
    logic             RegDst;
    logic             ALUSrc;
    logic             MemtoReg;
    logic [1:0]       ExtOp;
    logic [2:0]       ALUctr;
    logic             Illegal;
    logic             Fault;
    logic             Halted;
    logic [CNT_W-1:0] Retired;

    modport master (
        input  Opcode, Funct, Zero, Mem_Ready,
        output PCWr, nPC_sel, Jump, IRWr, InstRd, MemRd, MemWr, RegWr, RegDst,
               ALUSrc, MemtoReg, ExtOp, ALUctr, Illegal, Fault, Halted, Retired
    );

    modport slave (
        output Opcode, Funct, Zero, Mem_Ready,
        input  PCWr, nPC_sel, Jump, IRWr, InstRd, MemRd, MemWr, RegWr, RegDst,
               ALUSrc, MemtoReg, ExtOp, ALUctr, Illegal, Fault, Halted, Retired
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control sequencer with memory-wait watchdog
module mc_controller #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input logic           Clk,
    input logic           Reset,
    mc_controller_if.master bus
);
    localparam int WCW = $clog2(WAIT_LIMIT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_BAD
    } instr_t;

    state_t           state_q, state_d;
    instr_t           instr;
    logic [WCW-1:0]   wait_q;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q, fault_q;
    logic             retire, set_illegal, set_fault, timeout;
    logic             exe_src;
    logic [1:0]       exe_ext;
    logic [2:0]       exe_ctr;

    logic             pc_wr, npc_sel, jump, ir_wr, inst_rd, mem_rd, mem_wr;
    logic             reg_wr, reg_dst, alu_src, mem_to_reg;
    logic [1:0]       ext_op;
    logic [2:0]       alu_ctr;

    // Decode plus the ALU/extender setting each instruction needs in EXE.
    always_comb begin
        instr   = I_BAD;
        exe_src = 1'b0;
        exe_ext = 2'b00;
        exe_ctr = 3'b000;
        case (bus.Opcode)
            6'b000000: begin
                if (bus.Funct == 6'b100001) begin
                    instr = I_ADDU;
                end else if (bus.Funct == 6'b100011) begin
                    instr   = I_SUBU;
                    exe_ctr = 3'b001;
                end
            end
            6'b001101: begin
                instr   = I_ORI;
                exe_src = 1'b1;
                exe_ctr = 3'b010;
            end
            6'b001111: begin
                instr   = I_LUI;
                exe_src = 1'b1;
                exe_ext = 2'b10;
            end
            6'b100011: begin
                instr   = I_LW;
                exe_src = 1'b1;
                exe_ext = 2'b01;
            end
            6'b101011: begin
                instr   = I_SW;
                exe_src = 1'b1;
                exe_ext = 2'b01;
            end
            6'b000100: begin
                instr   = I_BEQ;
                exe_ext = 2'b01;
                exe_ctr = 3'b001;
            end
            6'b000010: instr = I_J;
            default:   instr = I_BAD;
        endcase
    end

    assign timeout = (wait_q == WCW'(WAIT_LIMIT)) && !bus.Mem_Ready;

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        pc_wr       = 1'b0;
        npc_sel     = 1'b0;
        jump        = 1'b0;
        ir_wr       = 1'b0;
        inst_rd     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        reg_dst     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        ext_op      = 2'b00;
        alu_ctr     = 3'b000;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                inst_rd = 1'b1;
                if (bus.Mem_Ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_ID;
                end else if (timeout) begin
                    set_fault = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_ID: begin
                if (instr == I_J) begin
                    pc_wr   = 1'b1;
                    jump    = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (instr == I_BAD) begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alu_src = exe_src;
                ext_op  = exe_ext;
                alu_ctr = exe_ctr;
                if (instr == I_BEQ) begin
                    pc_wr   = bus.Zero;
                    npc_sel = bus.Zero;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (instr == I_LW || instr == I_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Address path stays at its EXE setting for the whole access.
                alu_src = exe_src;
                ext_op  = exe_ext;
                alu_ctr = exe_ctr;
                mem_wr  = (instr == I_SW);
                mem_rd  = (instr != I_SW);
                if (bus.Mem_Ready) begin
                    if (instr == I_SW) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    set_fault = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (instr == I_ADDU) || (instr == I_SUBU);
                mem_to_reg = (instr == I_LW);
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || bus.Mem_Ready) begin
                wait_q <= '0;
            end else if (state_q == S_IF || state_q == S_MEM) begin
                wait_q <= wait_q + WCW'(1);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.PCWr     = pc_wr;
    assign bus.nPC_sel  = npc_sel;
    assign bus.Jump     = jump;
    assign bus.IRWr     = ir_wr;
    assign bus.InstRd   = inst_rd;
    assign bus.MemRd    = mem_rd;
    assign bus.MemWr    = mem_wr;
    assign bus.RegWr    = reg_wr;
    assign bus.RegDst   = reg_dst;
    assign bus.ALUSrc   = alu_src;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.ExtOp    = ext_op;
    assign bus.ALUctr   = alu_ctr;
    assign bus.Illegal  = illegal_q;
    assign bus.Fault    = fault_q;
    assign bus.Halted   = (state_q == S_HALT);
    assign bus.Retired  = retired_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller
module tb_mc_controller;
    localparam int WL = 4;
    localparam int CW = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   total;
    int   bad;
    int   exp_ret;

    mc_controller_if #(.CNT_W(CW)) bus ();

    mc_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    // Expected per-instruction activity, derived from the instruction set rules.
    typedef struct {
        int         lat;
        int         instrd;
        int         irwr;
        int         pcwr;
        int         jump;
        int         npc;
        int         memrd;
        int         memwr;
        int         regwr;
        int         dst;
        int         m2r;
        int         has_exe;
        logic [5:0] exe;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ctrl_vec();
        return {bus.PCWr, bus.nPC_sel, bus.Jump, bus.IRWr, bus.InstRd, bus.MemRd,
                bus.MemWr, bus.RegWr, bus.RegDst, bus.ALUSrc, bus.MemtoReg,
                bus.ExtOp, bus.ALUctr};
    endfunction

    // kinds: 0 addu, 1 subu, 2 ori, 3 lui, 4 lw, 5 sw, 6 beq, 7 j
    task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            0:       begin op = 6'b000000; fn = 6'b100001; end
            1:       begin op = 6'b000000; fn = 6'b100011; end
            2:       op = 6'b001101;
            3:       op = 6'b001111;
            4:       op = 6'b100011;
            5:       op = 6'b101011;
            6:       op = 6'b000100;
            default: op = 6'b000010;
        endcase
    endtask

    function automatic exp_t model(input int k, input int s_if, input int s_mem, input int zero);
        exp_t e;
        e = '{lat: 4, instrd: 1 + s_if, irwr: 1, pcwr: 1, jump: 0, npc: 0, memrd: 0,
              memwr: 0, regwr: 0, dst: 0, m2r: 0, has_exe: 1, exe: 6'b0};
        case (k)
            0: begin e.regwr = 1; e.dst = 1; e.exe = 6'b0_00_000; end
            1: begin e.regwr = 1; e.dst = 1; e.exe = 6'b0_00_001; end
            2: begin e.regwr = 1; e.exe = 6'b1_00_010; end
            3: begin e.regwr = 1; e.exe = 6'b1_10_000; end
            4: begin e.lat = 5 + s_mem; e.memrd = 1 + s_mem; e.regwr = 1; e.m2r = 1;
                     e.exe = 6'b1_01_000; end
            5: begin e.lat = 4 + s_mem; e.memwr = 1 + s_mem; e.exe = 6'b1_01_000; end
            6: begin e.lat = 3; e.pcwr = 1 + zero; e.npc = zero; e.exe = 6'b0_01_001; end
            default: begin e.lat = 2; e.pcwr = 2; e.jump = 1; e.has_exe = 0; end
        endcase
        e.lat = e.lat + s_if;
        return e;
    endfunction

    // Starts at a falling edge with the DUT in IF; acts as a memory with fixed stalls.
    task automatic run_instr(input int k, input int s_if, input int s_mem, input int zero);
        exp_t       e;
        logic [5:0] op, fn, exe_obs, cur;
        int         waited, st, hold_bad;
        int         n_ird, n_irw, n_pcw, n_jmp, n_npc, n_mrd, n_mwr, n_rgw, n_dst, n_m2r;
        e = model(k, s_if, s_mem, zero);
        enc(k, op, fn);
        bus.Opcode = op;
        bus.Funct  = fn;
        bus.Zero   = zero[0];
        waited = 0; hold_bad = 0; exe_obs = 6'h3f;
        n_ird = 0; n_irw = 0; n_pcw = 0; n_jmp = 0; n_npc = 0;
        n_mrd = 0; n_mwr = 0; n_rgw = 0; n_dst = 0; n_m2r = 0;
        for (int c = 0; c < e.lat; c++) begin
            if (bus.InstRd || bus.MemRd || bus.MemWr) begin
                st = bus.InstRd ? s_if : s_mem;
                if (waited == st) begin
                    bus.Mem_Ready = 1'b1;
                    waited = 0;
                end else begin
                    bus.Mem_Ready = 1'b0;
                    waited++;
                end
            end else begin
                bus.Mem_Ready = 1'($urandom_range(0, 1));
            end
            #1;
            cur = {bus.ALUSrc, bus.ExtOp, bus.ALUctr};
            n_ird += int'(bus.InstRd);  n_irw += int'(bus.IRWr);
            n_pcw += int'(bus.PCWr);    n_jmp += int'(bus.Jump);
            n_npc += int'(bus.nPC_sel); n_mrd += int'(bus.MemRd);
            n_mwr += int'(bus.MemWr);   n_rgw += int'(bus.RegWr);
            n_dst += int'(bus.RegDst);  n_m2r += int'(bus.MemtoReg);
            if (e.has_exe != 0 && c == s_if + 2) exe_obs = cur;
            if ((bus.MemRd || bus.MemWr) && cur != e.exe) hold_bad++;
            @(negedge Clk);
        end
        chk($sformatf("k%0d instrd", k), n_ird, e.instrd);
        chk($sformatf("k%0d irwr", k),   n_irw, e.irwr);
        chk($sformatf("k%0d pcwr", k),   n_pcw, e.pcwr);
        chk($sformatf("k%0d jump", k),   n_jmp, e.jump);
        chk($sformatf("k%0d npc", k),    n_npc, e.npc);
        chk($sformatf("k%0d memrd", k),  n_mrd, e.memrd);
        chk($sformatf("k%0d memwr", k),  n_mwr, e.memwr);
        chk($sformatf("k%0d regwr", k),  n_rgw, e.regwr);
        chk($sformatf("k%0d regdst", k), n_dst, e.dst);
        chk($sformatf("k%0d memtoreg", k), n_m2r, e.m2r);
        if (e.has_exe != 0) chk($sformatf("k%0d exe_ctl", k), exe_obs, e.exe);
        chk($sformatf("k%0d mem_hold", k), hold_bad, 0);
        chk($sformatf("k%0d back_in_if", k), {bus.Halted, bus.InstRd}, 2'b01);
        exp_ret = (exp_ret + 1) % (1 << CW);
        chk($sformatf("k%0d retired", k), bus.Retired, exp_ret);
    endtask

    task automatic reset_dut(input string tag);
        Reset = 1'b0;
        #1;
        chk($sformatf("%s rst_ctrl", tag), ctrl_vec(), 16'h0);
        chk($sformatf("%s rst_flags", tag), {bus.Illegal, bus.Fault, bus.Halted}, 3'b000);
        chk($sformatf("%s rst_retired", tag), bus.Retired, 0);
        @(negedge Clk);
        Reset = 1'b1;
        exp_ret = 0;
        #1;
        chk($sformatf("%s idle", tag), {bus.Halted, bus.InstRd}, 2'b00);
        @(negedge Clk);
        chk($sformatf("%s first_if", tag), bus.InstRd, 1'b1);
    endtask

    task automatic illegal(input logic [5:0] op, input logic [5:0] fn);
        int n_ird, n_pcw, n_oth;
        bus.Opcode = op;
        bus.Funct  = fn;
        n_ird = 0; n_pcw = 0; n_oth = 0;
        for (int c = 0; c < 8; c++) begin
            bus.Mem_Ready = bus.InstRd ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            n_ird += int'(bus.InstRd);
            n_pcw += int'(bus.PCWr);
            n_oth += int'(bus.RegWr) + int'(bus.MemRd) + int'(bus.MemWr) + int'(bus.Jump);
            @(negedge Clk);
        end
        chk("ill instrd", n_ird, 1);
        chk("ill pcwr", n_pcw, 1);
        chk("ill strobes", n_oth, 0);
        chk("ill flags", {bus.Illegal, bus.Fault, bus.Halted}, 3'b101);
        chk("ill retired", bus.Retired, exp_ret);
    endtask

    task automatic watchdog(input int k, input bit in_mem);
        logic [5:0] op, fn;
        int         n_str, n_after;
        enc(k, op, fn);
        bus.Opcode = op;
        bus.Funct  = fn;
        n_str = 0; n_after = 0;
        for (int c = 0; c < 14; c++) begin
            bus.Mem_Ready = in_mem ? bus.InstRd : 1'b0;
            #1;
            n_str += in_mem ? int'(bus.MemRd) : int'(bus.InstRd);
            @(negedge Clk);
        end
        chk($sformatf("wd%0d strobe_cycles", in_mem), n_str, WL + 1);
        chk($sformatf("wd%0d flags", in_mem), {bus.Illegal, bus.Fault, bus.Halted}, 3'b011);
        for (int c = 0; c < 4; c++) begin
            bus.Mem_Ready = 1'b1;
            #1;
            n_after += int'(bus.InstRd) + int'(bus.MemRd) + int'(bus.MemWr) + int'(bus.PCWr);
            @(negedge Clk);
        end
        chk($sformatf("wd%0d after_ready", in_mem), n_after, 0);
        chk($sformatf("wd%0d still_halted", in_mem), bus.Halted, 1'b1);
        chk($sformatf("wd%0d retired", in_mem), bus.Retired, exp_ret);
    endtask

    task automatic sw_abort();
        logic [5:0] op, fn;
        enc(5, op, fn);
        bus.Opcode = op;
        bus.Funct  = fn;
        for (int c = 0; c < 4; c++) begin
            bus.Mem_Ready = bus.InstRd;
            #1;
            if (c < 3) @(negedge Clk);
        end
        chk("abort memwr_pre", bus.MemWr, 1'b1);
        #1 Reset = 1'b0;
        #1;
        chk("abort memwr_drop", bus.MemWr, 1'b0);
        reset_dut("abort");
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_ret = 0;
        bus.Opcode = '0;
        bus.Funct = '0;
        bus.Zero = 1'b0;
        bus.Mem_Ready = 1'b0;
        repeat (2) @(negedge Clk);
        reset_dut("por");
        run_instr(0, 0, 0, 0);
        run_instr(4, 0, 3, 0);
        run_instr(6, 0, 0, 1);
        run_instr(6, 0, 0, 0);
        run_instr(5, WL, WL, 0);
        for (int i = 0; i < 80; i++) begin
            run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, WL)),
                      int'($urandom_range(0, WL)), int'($urandom_range(0, 1)));
        end
        illegal(6'b111111, 6'($urandom));
        reset_dut("ill1");
        illegal(6'b000000, 6'b100000);
        reset_dut("ill2");
        watchdog(0, 1'b0);
        reset_dut("wd_if");
        watchdog(4, 1'b1);
        reset_dut("wd_mem");
        sw_abort();
        run_instr(7, 1, 0, 0);
        run_instr(5, 0, 2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
